alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 204 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle
//
// Multi-cycle ALU with a valid/ready request port and a valid/ready result
// port. Logic, add/sub, compare and shift operations finish one cycle after
// acceptance. MUL, MULHU, DIVU and REMU run a bit-serial datapath for exactly
// WIDTH iterations before the result is presented.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   high only while idle; a request is taken when both are high
//   op         operation select (0 ADD .. 14 REMU, 15 reserved -> 0)
//   a, b       operands, captured on acceptance
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   result     answer, registered
//   zero       high iff result == 0, registered alongside result

module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    count;

    logic             accept;
    logic             iterative;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_out;

    logic             is_mul;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] final_val;

    assign accept    = in_valid && in_ready;
    assign iterative = (op >= 4'd11) && (op <= 4'd14);
    assign shamt     = b[SHW-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = iterative ? ITER : DONE;
                end
            end
            ITER: begin
                if (count == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Single-cycle operations, evaluated directly on the incoming operands
    always_comb begin
        alu_out = '0;
        case (op)
            4'd0:    alu_out = a + b;
            4'd1:    alu_out = a + ~b + WIDTH'(1);
            4'd2:    alu_out = a & b;
            4'd3:    alu_out = a | b;
            4'd4:    alu_out = a ^ b;
            4'd5:    alu_out = ~(a | b);
            4'd6:    alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd7:    alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd8:    alu_out = a << shamt;
            4'd9:    alu_out = a >> shamt;
            4'd10:   alu_out = $unsigned($signed(a) >>> shamt);
            default: alu_out = '0;
        endcase
    end

    // One iteration of the serial datapath. hi/lo are shared:
    //  multiply: {hi,lo} is the partial product, lo initially holds the
    //            multiplier; each step adds a_q into hi when lo[0] is set and
    //            shifts the whole thing right, carry included.
    //  divide:   hi is the partial remainder, lo initially holds the dividend
    //            and fills with quotient bits from the right. A zero divisor
    //            makes every trial subtraction succeed, which naturally gives
    //            an all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        is_mul  = (op_q == 4'd11) || (op_q == 4'd12);

        mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? a_q : {WIDTH{1'b0}})};
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo[WIDTH-1:1]};

        rem_sh  = {hi, lo[WIDTH-1]};
        div_ge  = (rem_sh >= {1'b0, b_q});
        div_hi  = div_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
        div_lo  = {lo[WIDTH-2:0], div_ge};

        step_hi = is_mul ? mul_hi : div_hi;
        step_lo = is_mul ? mul_lo : div_lo;

        // MUL and DIVU (odd codes) take the low half, MULHU and REMU the high
        final_val = op_q[0] ? step_lo : step_hi;
    end

    // Datapath registers: operand capture, iteration, and the result/zero
    // pair, which are always written together so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        hi    <= '0;
                        lo    <= (op == 4'd11 || op == 4'd12) ? b : a;
                        count <= '0;
                        if (!iterative) begin
                            result <= alu_out;
                            zero   <= (alu_out == '0);
                        end
                    end
                end
                ITER: begin
                    hi    <= step_hi;
                    lo    <= step_lo;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        result <= final_val;
                        zero   <= (final_val == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle.
// Requests are issued by applyStimulus, which pushes the reference answer and
// expected latency into a scoreboard queue. An independent monitor checks
// every cycle: in_ready, latency to first out_valid, result/zero stability
// while stalled, and the idle cycle that follows each output handshake.

module tb_alu_multicycle;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   seen = 0;
    bit   hs_prev = 0;
    int   ready_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model written from the operation definitions
    function automatic logic [31:0] model(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        int sh;
        p  = 64'(x) * 64'(y);
        sh = int'(y[4:0]);
        case (f)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return x ^ y;
            4'd5:    return ~(x | y);
            4'd6:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd7:    return (x < y) ? 32'd1 : 32'd0;
            4'd8:    return x << sh;
            4'd9:    return x >> sh;
            4'd10:   return $unsigned($signed(x) >>> sh);
            4'd11:   return p[31:0];
            4'd12:   return p[63:32];
            4'd13:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd14:   return (y == 0) ? x : x % y;
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportFail(input string name);
        tests++;
        failed++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic applyStimulus(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
        int   waited = 0;
        bit   got = 0;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op = f;
        a = x;
        b = y;
        while (!got && waited < 300) begin
            @(negedge clk);
            #1;
            if (in_ready) begin
                got   = 1;
                e.res = model(f, x, y);
                e.zero = (e.res == 32'd0);
                e.acc = cyc;
                e.lat = (f >= 4'd11 && f <= 4'd14) ? WIDTH + 1 : 1;
                sb.push_back(e);
            end else begin
                waited++;
            end
        end
        if (!got) begin
            reportFail("accept_timeout");
            in_valid = 1'b0;
        end else begin
            // Garbage on the inputs right after acceptance must be ignored
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            op = 4'($urandom);
            a = $urandom;
            b = $urandom;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int w = 0;
        idleCycles(1);
        while (sb.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) reportFail("drain_timeout");
    endtask

    task automatic doReset(input bit check);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        seen = 0;
        hs_prev = 0;
        mon_en = 1;
        if (check) begin
            @(negedge clk);
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_result", result, 32'd0);
            checkOutput("rst_zero", 32'(zero), 32'd1);
            checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 40));
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // out_ready driver: random, always high, or held low
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every cycle, compare DUT behaviour against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                checkOutput("in_ready", 32'(in_ready), 32'(sb.size() == 0));
                if (hs_prev) checkOutput("out_valid_after_hs", 32'(out_valid), 32'd0);
                hs_prev = 0;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        reportFail("unexpected_output");
                    end else begin
                        if (!seen) begin
                            seen = 1;
                            checkOutput("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                        end
                        checkOutput("result", result, sb[0].res);
                        checkOutput("zero", 32'(zero), 32'(sb[0].zero));
                        if (out_ready) begin
                            void'(sb.pop_front());
                            seen = 0;
                            hs_prev = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        in_valid = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        doReset(1'b1);

        // Directed corner cases
        ready_mode = 1;
        applyStimulus(4'd0,  32'h7FFF_FFFF, 32'h0000_0001);
        applyStimulus(4'd6,  32'hFFFF_FFFF, 32'h0000_0001);
        applyStimulus(4'd7,  32'hFFFF_FFFF, 32'h0000_0001);
        applyStimulus(4'd10, 32'h8000_0000, 32'h0000_0024);
        applyStimulus(4'd11, 32'h0001_0000, 32'h0001_0000);
        applyStimulus(4'd12, 32'h0001_0000, 32'h0001_0000);
        applyStimulus(4'd13, 32'd100, 32'd7);
        applyStimulus(4'd14, 32'd100, 32'd7);
        applyStimulus(4'd13, 32'd5, 32'd0);
        applyStimulus(4'd14, 32'd5, 32'd0);
        applyStimulus(4'd1,  32'd0, 32'd1);
        applyStimulus(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
        waitDrain();

        // Stall in DONE for 5 cycles, then release and issue back-to-back
        ready_mode = 2;
        applyStimulus(4'd4, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) reportFail("stall_wait_timeout");
        repeat (5) @(posedge clk);
        ready_mode = 1;
        applyStimulus(4'd8, 32'h0000_0001, 32'hFFFF_FFFF);
        applyStimulus(4'd9, 32'h8000_0000, 32'h0000_003F);
        waitDrain();

        // Reset in the middle of a divide: nothing may be emitted afterwards
        applyStimulus(4'd13, 32'hDEAD_BEEF, 32'h0000_0013);
        repeat (8) @(posedge clk);
        doReset(1'b1);

        // Randomised traffic with random backpressure
        ready_mode = 0;
        for (int i = 0; i < 120; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand());
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end
        ready_mode = 1;
        waitDrain();
        idleCycles(3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
